// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side handshake/operand bus plus the ALU pin bundle
// for alu_arbiter. The slave modport is the arbiter itself; the master modport
// is whatever drives the requests and models the ALU (requesters + ALU).
interface alu_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 4
);
    // requester port 0 (main datapath) and port 1 (address/branch unit)
    logic             req0;
    logic             req1;
    logic [SELW-1:0]  op0;
    logic [SELW-1:0]  op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] res;
    logic             zf;
    logic             busy;

    // ALU pins
    logic [SELW-1:0]  alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        input  alu_result, alu_zero,
        output gnt0, gnt1, done0, done1, res, zf, busy,
        output alu_sel, alu_a, alu_b
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        output alu_result, alu_zero,
        input  gnt0, gnt1, done0, done1, res, zf, busy,
        input  alu_sel, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one WIDTH-bit ALU between two requesters.
// One operation in flight at a time: IDLE -> EXEC -> DONE -> IDLE.
// The winner's select code and operands are latched and drive the ALU from
// registers; the ALU result and zero flag are captured one cycle later and
// returned to the granted port with a single-cycle done pulse.
// Ties are resolved round-robin by default. Defining ALU_ARB_FIXED_PRIO_EN
// selects fixed priority instead (port 0 always wins, no 'last' register).
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int SELW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             owner_r;
    logic             any_req_s;
    logic             win_s;

    logic             gnt0_r;
    logic             gnt1_r;
    logic             done0_r;
    logic             done1_r;
    logic             busy_r;
    logic [SELW-1:0]  alu_sel_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [WIDTH-1:0] res_r;
    logic             zf_r;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_r;
`endif

    assign any_req_s = bus.req0 | bus.req1;

    // Winner selection: a lone requester always wins; ties use round-robin
    // (the port that did not win last time) or fixed priority to port 0.
    always_comb begin
        win_s = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ~last_r;
`endif
        end else if (bus.req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, handshake pulses, operand latch and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            owner_r   <= 1'b0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            busy_r    <= 1'b0;
            alu_sel_r <= {SELW{1'b0}};
            alu_a_r   <= {WIDTH{1'b0}};
            alu_b_r   <= {WIDTH{1'b0}};
            res_r     <= {WIDTH{1'b0}};
            zf_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_r   <= win_s;
                        gnt0_r    <= ~win_s;
                        gnt1_r    <= win_s;
                        alu_sel_r <= win_s ? bus.op1 : bus.op0;
                        alu_a_r   <= win_s ? bus.a1  : bus.a0;
                        alu_b_r   <= win_s ? bus.b1  : bus.b0;
                    end
                end
                ST_EXEC: begin
                    res_r   <= bus.alu_result;
                    zf_r    <= bus.alu_zero;
                    done0_r <= ~owner_r;
                    done1_r <= owner_r;
                end
                ST_DONE: begin
                    // return to IDLE; requests deliberately ignored here
                end
                default: begin
                    // illegal encoding recovers through state_nxt_s
                end
            endcase
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin history: remember the port granted most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            last_r <= win_s;
        end
    end
`endif

    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.done0   = done0_r;
    assign bus.done1   = done1_r;
    assign bus.busy    = busy_r;
    assign bus.res     = res_r;
    assign bus.zf      = zf_r;
    assign bus.alu_sel = alu_sel_r;
    assign bus.alu_a   = alu_a_r;
    assign bus.alu_b   = alu_b_r;

endmodule
